// File: rtl/b4_pkg.sv
// Shared definitions for the b4 serial-to-parallel deserializer.
// Holds the FSM state encoding and the default word width.
package b4_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/b4_deser.sv
// Serial-to-parallel deserializer: frame marks the first bit of a word, the
// completed word is handed to a single-entry valid/ready output register.
module b4_deser
  import b4_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             frame,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  output logic             busy,
  output logic             resync,
  output logic             overrun
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_sr, w_sr_d, w_shifted;
  logic [WIDTH-1:0] r_dout, w_dout_d;
  logic             r_valid, w_valid_d;
  logic             r_resync, w_resync_d;
  logic             r_overrun, w_overrun_d;
  logic             w_done;

  // The word completes with the current sin, so the output takes w_shifted.
  always_comb begin
    if (MSB_FIRST) begin
      w_shifted = {r_sr[WIDTH-2:0], sin};
    end else begin
      w_shifted = {sin, r_sr[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_sr_d     = r_sr;
    w_done     = 1'b0;
    w_resync_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (frame) begin
          w_sr_d    = w_shifted;
          w_cnt_d   = CntW'(1);
          w_state_d = StShift;
        end
      end
      StShift: begin
        w_sr_d = w_shifted;
        if (frame) begin
          // Frame mid-word: drop the partial word and restart on this bit.
          w_cnt_d    = CntW'(1);
          w_resync_d = 1'b1;
        end else if (r_cnt == CntLast) begin
          w_done    = 1'b1;
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_dout_d    = r_dout;
    w_valid_d   = r_valid;
    w_overrun_d = r_overrun;
    if (w_done) begin
      if (!r_valid || out_ready) begin
        w_dout_d  = w_shifted;
        w_valid_d = 1'b1;
      end else begin
        w_overrun_d = 1'b1;
      end
    end else if (r_valid && out_ready) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_resync  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_sr      <= w_sr_d;
      r_dout    <= w_dout_d;
      r_valid   <= w_valid_d;
      r_resync  <= w_resync_d;
      r_overrun <= w_overrun_d;
    end
  end

  assign dout      = r_dout;
  assign out_valid = r_valid;
  assign busy      = (r_state == StShift);
  assign resync    = r_resync;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_b4_deser.sv
// Directed bench for b4_deser: a per-cycle vector table on an MSB-first
// instance plus short hand sequences, including an LSB-first instance.
module tb_b4_deser;

  typedef struct packed {
    logic       rst;
    logic       frame;
    logic       sin;
    logic       rdy;
    logic [3:0] dout;
    logic       vld;
    logic       busy;
    logic       rsy;
    logic       ovr;
  } vec_t;

  localparam int NumVec = 44;

  logic       clk = 1'b0;
  logic       rst, sin, frame, out_ready;
  logic [3:0] m_dout, l_dout;
  logic       m_valid, m_busy, m_resync, m_overrun;
  logic       l_valid, l_busy, l_resync, l_overrun;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t vecs [NumVec];

  always #5 clk = ~clk;

  b4_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .frame     (frame),
    .out_ready (out_ready),
    .dout      (m_dout),
    .out_valid (m_valid),
    .busy      (m_busy),
    .resync    (m_resync),
    .overrun   (m_overrun)
  );

  b4_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .frame     (frame),
    .out_ready (out_ready),
    .dout      (l_dout),
    .out_valid (l_valid),
    .busy      (l_busy),
    .resync    (l_resync),
    .overrun   (l_overrun)
  );

  function automatic vec_t mk(input logic r, input logic f, input logic s, input logic rd,
                              input logic [3:0] d, input logic v, input logic b,
                              input logic rs, input logic o);
    vec_t t;
    t = '{rst: r, frame: f, sin: s, rdy: rd, dout: d, vld: v, busy: b, rsy: rs, ovr: o};
    return t;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic step(input logic r, input logic f, input logic s, input logic rd);
    rst       = r;
    frame     = f;
    sin       = s;
    out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    // rst frame sin rdy | dout vld busy rsy ovr
    vecs[0]  = mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 0);  // reset
    vecs[1]  = mk(0, 0, 1, 1, 4'h0, 0, 0, 0, 0);  // idle ignores sin
    vecs[2]  = mk(0, 1, 0, 1, 4'h0, 0, 1, 0, 0);  // word 0001
    vecs[3]  = mk(0, 0, 0, 1, 4'h0, 0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 4'h0, 0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 1, 1, 4'h1, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 4'h1, 0, 0, 0, 0);  // consumed
    vecs[7]  = mk(0, 1, 1, 1, 4'h1, 0, 1, 0, 0);  // partial 1,1
    vecs[8]  = mk(0, 0, 1, 1, 4'h1, 0, 1, 0, 0);
    vecs[9]  = mk(0, 1, 0, 1, 4'h1, 0, 1, 1, 0);  // restart -> resync
    vecs[10] = mk(0, 0, 1, 1, 4'h1, 0, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 1, 4'h1, 0, 1, 0, 0);
    vecs[12] = mk(0, 0, 1, 1, 4'h5, 1, 0, 0, 0);
    vecs[13] = mk(0, 1, 1, 1, 4'h5, 0, 1, 0, 0);  // word 1001
    vecs[14] = mk(0, 0, 0, 1, 4'h5, 0, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 1, 4'h5, 0, 1, 0, 0);
    vecs[16] = mk(0, 0, 1, 1, 4'h9, 1, 0, 0, 0);
    vecs[17] = mk(0, 1, 0, 1, 4'h9, 0, 1, 0, 0);  // back-to-back 0110
    vecs[18] = mk(0, 0, 1, 1, 4'h9, 0, 1, 0, 0);
    vecs[19] = mk(0, 0, 1, 1, 4'h9, 0, 1, 0, 0);
    vecs[20] = mk(0, 0, 0, 1, 4'h6, 1, 0, 0, 0);
    vecs[21] = mk(0, 1, 1, 1, 4'h6, 0, 1, 0, 0);  // word 1010, stalled
    vecs[22] = mk(0, 0, 0, 0, 4'h6, 0, 1, 0, 0);
    vecs[23] = mk(0, 0, 1, 0, 4'h6, 0, 1, 0, 0);
    vecs[24] = mk(0, 0, 0, 0, 4'hA, 1, 0, 0, 0);
    vecs[25] = mk(0, 1, 0, 0, 4'hA, 1, 1, 0, 0);  // word 0011 dropped
    vecs[26] = mk(0, 0, 0, 0, 4'hA, 1, 1, 0, 0);
    vecs[27] = mk(0, 0, 1, 0, 4'hA, 1, 1, 0, 0);
    vecs[28] = mk(0, 0, 1, 0, 4'hA, 1, 0, 0, 1);
    vecs[29] = mk(0, 0, 0, 1, 4'hA, 0, 0, 0, 1);  // overrun sticky
    vecs[30] = mk(0, 1, 1, 0, 4'hA, 0, 1, 0, 1);  // word 1100
    vecs[31] = mk(0, 0, 1, 0, 4'hA, 0, 1, 0, 1);
    vecs[32] = mk(0, 0, 0, 0, 4'hA, 0, 1, 0, 1);
    vecs[33] = mk(0, 0, 0, 0, 4'hC, 1, 0, 0, 1);
    vecs[34] = mk(0, 1, 0, 0, 4'hC, 1, 1, 0, 1);  // two bits then reset
    vecs[35] = mk(0, 0, 1, 0, 4'hC, 1, 1, 0, 1);
    vecs[36] = mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    vecs[37] = mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    vecs[38] = mk(0, 1, 0, 0, 4'h0, 0, 1, 0, 0);  // fresh word 0111
    vecs[39] = mk(0, 0, 1, 0, 4'h0, 0, 1, 0, 0);
    vecs[40] = mk(0, 0, 1, 0, 4'h0, 0, 1, 0, 0);
    vecs[41] = mk(0, 0, 1, 0, 4'h7, 1, 0, 0, 0);
    vecs[42] = mk(0, 0, 0, 0, 4'h7, 1, 0, 0, 0);  // held while stalled
    vecs[43] = mk(0, 0, 0, 1, 4'h7, 0, 0, 0, 0);

    rst = 1'b1; frame = 1'b0; sin = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NumVec; i++) begin
      step(vecs[i].rst, vecs[i].frame, vecs[i].sin, vecs[i].rdy);
      check($sformatf("vec%0d", i),
            {m_dout, m_valid, m_busy, m_resync, m_overrun},
            {vecs[i].dout, vecs[i].vld, vecs[i].busy, vecs[i].rsy, vecs[i].ovr});
    end

    // LSB-first: stream 1,0,1,1 gives 4'hD; the MSB-first instance sees 4'hB.
    step(1, 0, 0, 1);
    step(0, 1, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    check("lsb_latency", {4'h0, l_valid, l_busy, 2'b00}, {4'h0, 1'b0, 1'b1, 2'b00});
    step(0, 0, 1, 1);
    check("lsb_word", {l_dout, l_valid, l_busy, l_resync, l_overrun}, {4'hD, 4'b1000});
    check("msb_same_stream", {m_dout, m_valid, m_busy, m_resync, m_overrun}, {4'hB, 4'b1000});
    step(0, 0, 0, 1);
    check("lsb_consumed", {l_dout, l_valid, l_busy, l_resync, l_overrun}, {4'hD, 4'b0000});

    // Frame on what would have been the last bit restarts instead of completing.
    step(0, 1, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 1, 1);
    check("late_frame", {m_dout, m_valid, m_busy, m_resync, m_overrun}, {4'hB, 4'b0110});
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    check("late_frame_word", {m_dout, m_valid, m_busy, m_resync, m_overrun}, {4'hA, 4'b1000});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
